// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - read, write and issue bus of the multi-port register file
interface reg_file_mp_if #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_RD*AW-1:0]   rd_reg;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic [NUM_WR-1:0]      wr_en;
   logic [NUM_WR*AW-1:0]   wr_reg;
   logic [NUM_WR*XLEN-1:0] wr_data;
   logic                   issue_en;
   logic [AW-1:0]          issue_reg;
   logic                   any_busy;

   modport master (
      output rd_reg,
      input  rd_data,
      input  rd_busy,
      output wr_en,
      output wr_reg,
      output wr_data,
      output issue_en,
      output issue_reg,
      input  any_busy
   );

   modport slave (
      input  rd_reg,
      output rd_data,
      output rd_busy,
      input  wr_en,
      input  wr_reg,
      input  wr_data,
      input  issue_en,
      input  issue_reg,
      output any_busy
   );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with busy scoreboard; REG_FILE_BYPASS_EN adds write-first forwarding
module reg_file_mp #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_mp_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   logic [XLEN-1:0]     regs_q [NUM_REGS];
   logic [XLEN-1:0]     regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                any_busy_q;
   logic                any_busy_d;

   logic [AW-1:0]       rd_addr [NUM_RD];
   logic [XLEN-1:0]     rd_val  [NUM_RD];
   logic                rd_bsy  [NUM_RD];

   // Next state: writes in ascending port order so the highest port wins, then
   // issue sets busy after write clears so a new producer keeps the register busy.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (bus.wr_en[j] && (bus.wr_reg[j*AW +: AW] != '0)) begin
            regs_d[bus.wr_reg[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
            busy_d[bus.wr_reg[j*AW +: AW]] = 1'b0;
         end
      end
      if (bus.issue_en && (bus.issue_reg != '0)) begin
         busy_d[bus.issue_reg] = 1'b1;
      end
      regs_d[0]  = '0;
      busy_d[0]  = 1'b0;
      any_busy_d = |busy_d;
   end

   // State register; reset clears storage and scoreboard ahead of any write or issue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         any_busy_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         any_busy_q <= any_busy_d;
      end
   end

   // Combinational read of each port, optionally forwarding same-cycle write data.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_addr[i] = bus.rd_reg[i*AW +: AW];
         rd_val[i]  = regs_q[rd_addr[i]];
         rd_bsy[i]  = busy_q[rd_addr[i]];
`ifdef REG_FILE_BYPASS_EN
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && (bus.wr_reg[j*AW +: AW] != '0) &&
                (bus.wr_reg[j*AW +: AW] == rd_addr[i])) begin
               rd_val[i] = bus.wr_data[j*XLEN +: XLEN];
               rd_bsy[i] = bus.issue_en && (bus.issue_reg == rd_addr[i]);
            end
         end
`endif
         if (rd_addr[i] == '0) begin
            rd_val[i] = '0;
            rd_bsy[i] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      assign bus.rd_data[g*XLEN +: XLEN] = rd_val[g];
      assign bus.rd_busy[g]              = rd_bsy[g];
   end

   assign bus.any_busy = any_busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed and random checks of reg_file_mp against a behavioural model
module tb_reg_file_mp;
   localparam int XLEN = 32;
   localparam int NR   = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic clk;
   logic rst_n;

   reg_file_mp_if #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

   reg_file_mp #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int              n_assert = 0;
   int              n_fail   = 0;
   logic [31:0]     m_regs [NR];
   logic [NR-1:0]   m_busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit write_hits(input int a);
      bit hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && a != 0 && int'(bus.wr_reg[j*AW +: AW]) == a) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic [31:0] exp_data(input int a);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      v = m_regs[a];
`ifdef REG_FILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && int'(bus.wr_reg[j*AW +: AW]) == a) v = bus.wr_data[j*XLEN +: XLEN];
      end
`endif
      return v;
   endfunction

   function automatic logic [31:0] exp_busy(input int a);
      logic b;
      if (a == 0) return 32'h0;
      b = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
      if (write_hits(a)) b = bus.issue_en && (int'(bus.issue_reg) == a);
`endif
      return {31'h0, b};
   endfunction

   task automatic model_update();
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
         m_busy = '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_reg[j*AW +: AW] != 0) begin
               m_regs[bus.wr_reg[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
               m_busy[bus.wr_reg[j*AW +: AW]] = 1'b0;
            end
         end
         if (bus.issue_en && bus.issue_reg != 0) m_busy[bus.issue_reg] = 1'b1;
      end
   endtask

   task automatic drive_idle();
      bus.wr_en     = '0;
      bus.wr_reg    = '0;
      bus.wr_data   = '0;
      bus.issue_en  = 1'b0;
      bus.issue_reg = '0;
      bus.rd_reg    = '0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      bus.rd_reg[0 +: AW]  = AW'(a0);
      bus.rd_reg[AW +: AW] = AW'(a1);
   endtask

   task automatic check_reads();
      #1;
      for (int i = 0; i < NRD; i++) begin
         int a;
         a = int'(bus.rd_reg[i*AW +: AW]);
         check($sformatf("rd_data%0d[x%0d]", i, a), bus.rd_data[i*XLEN +: XLEN], exp_data(a));
         check($sformatf("rd_busy%0d[x%0d]", i, a), {31'h0, bus.rd_busy[i]}, exp_busy(a));
      end
   endtask

   task automatic tick();
      check_reads();
      @(posedge clk);
      model_update();
      #1;
      check("any_busy", {31'h0, bus.any_busy}, {31'h0, |m_busy});
   endtask

   function automatic int rnd_addr();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NR - 1));
      return int'($urandom_range(0, 7));
   endfunction

   initial begin
      // Reset with a write and an issue presented that must be lost.
      drive_idle();
      rst_n        = 1'b0;
      bus.wr_en    = 2'b11;
      bus.wr_reg   = {5'd4, 5'd4};
      bus.wr_data  = {32'h1234_5678, 32'h9ABC_DEF0};
      bus.issue_en = 1'b1;
      bus.issue_reg = 5'd4;
      @(posedge clk);
      model_update();
      #1;
      rst_n = 1'b1;
      drive_idle();
      for (int a = 0; a < NR; a++) begin
         set_rd(a, NR - 1 - a);
         #1;
         check($sformatf("rst_data0[x%0d]", a), bus.rd_data[0 +: XLEN], 32'h0);
         check($sformatf("rst_data1[x%0d]", NR - 1 - a), bus.rd_data[XLEN +: XLEN], 32'h0);
         check($sformatf("rst_busy[x%0d]", a), {30'h0, bus.rd_busy}, 32'h0);
      end
      check("rst_any_busy", {31'h0, bus.any_busy}, 32'h0);
      @(posedge clk);
      #1;

      // Write x5 and read it back next cycle alongside x0.
      drive_idle();
      bus.wr_en[0]          = 1'b1;
      bus.wr_reg[0 +: AW]   = 5'd5;
      bus.wr_data[0 +: XLEN] = 32'hDEAD_BEEF;
      tick();
      drive_idle();
      set_rd(5, 0);
      #1;
      check("x5_readback", bus.rd_data[0 +: XLEN], 32'hDEAD_BEEF);
      check("x0_readback", bus.rd_data[XLEN +: XLEN], 32'h0);

      // x0 protection against write and issue.
      drive_idle();
      bus.wr_en     = 2'b11;
      bus.wr_data   = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      bus.issue_en  = 1'b1;
      bus.issue_reg = 5'd0;
      tick();
      drive_idle();
      set_rd(0, 0);
      #1;
      check("x0_data", bus.rd_data[0 +: XLEN], 32'h0);
      check("x0_busy", {31'h0, bus.rd_busy[0]}, 32'h0);
      check("x0_any_busy", {31'h0, bus.any_busy}, 32'h0);

      // Write collision on x7: port 1 wins.
      drive_idle();
      bus.wr_en   = 2'b11;
      bus.wr_reg  = {5'd7, 5'd7};
      bus.wr_data = {32'h0000_2222, 32'h0000_1111};
      tick();
      drive_idle();
      set_rd(7, 7);
      #1;
      check("x7_collision", bus.rd_data[0 +: XLEN], 32'h0000_2222);

      // Scoreboard: issue, write+reissue, then write alone.
      drive_idle();
      bus.issue_en  = 1'b1;
      bus.issue_reg = 5'd3;
      tick();
      drive_idle();
      set_rd(3, 0);
      #1;
      check("x3_busy_after_issue", {31'h0, bus.rd_busy[0]}, 32'h1);
      bus.wr_en[0]           = 1'b1;
      bus.wr_reg[0 +: AW]    = 5'd3;
      bus.wr_data[0 +: XLEN] = 32'h0000_0033;
      bus.issue_en           = 1'b1;
      bus.issue_reg          = 5'd3;
      tick();
      drive_idle();
      set_rd(3, 0);
      #1;
      check("x3_busy_after_reissue", {31'h0, bus.rd_busy[0]}, 32'h1);
      check("x3_data_after_reissue", bus.rd_data[0 +: XLEN], 32'h0000_0033);
      bus.wr_en[0]           = 1'b1;
      bus.wr_reg[0 +: AW]    = 5'd3;
      bus.wr_data[0 +: XLEN] = 32'h0000_0044;
      tick();
      drive_idle();
      set_rd(3, 0);
      #1;
      check("x3_busy_cleared", {31'h0, bus.rd_busy[0]}, 32'h0);
      check("x3_any_busy_cleared", {31'h0, bus.any_busy}, 32'h0);

      // Same-cycle read and write of x9.
      drive_idle();
      bus.wr_en[0]           = 1'b1;
      bus.wr_reg[0 +: AW]    = 5'd9;
      bus.wr_data[0 +: XLEN] = 32'h0000_000A;
      tick();
      bus.wr_data[0 +: XLEN] = 32'h0000_000B;
      set_rd(9, 0);
      #1;
`ifdef REG_FILE_BYPASS_EN
      check("x9_same_cycle", bus.rd_data[0 +: XLEN], 32'h0000_000B);
`else
      check("x9_same_cycle", bus.rd_data[0 +: XLEN], 32'h0000_000A);
`endif
      tick();
      drive_idle();
      set_rd(9, 0);
      #1;
      check("x9_after_edge", bus.rd_data[0 +: XLEN], 32'h0000_000B);

      // Random traffic scored against the model.
      for (int n = 0; n < 1000; n++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         for (int j = 0; j < NWR; j++) begin
            bus.wr_en[j]              = 1'($urandom_range(0, 1));
            bus.wr_reg[j*AW +: AW]    = AW'(rnd_addr());
            bus.wr_data[j*XLEN +: XLEN] = $urandom;
         end
         bus.issue_en  = 1'($urandom_range(0, 1));
         bus.issue_reg = AW'(rnd_addr());
         set_rd(rnd_addr(), rnd_addr());
         tick();
      end
      rst_n = 1'b1;
      drive_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file with a per-register busy scoreboard. It is the next-generation replacement for the fixed 2-read/1-write RV32I register file, with configurable read-port count, write-port count, width and depth. The scoreboard gives the pipeline hazard and stall information without any external tracking logic. It sits in the decode/writeback stage of the core.

## Interface
- XLEN, 32, data width in bits.
- NUM_REGS, 32, register count; power of two, at least 2. Register 0 is hardwired to zero.
- NUM_RD, 2, read ports, 1..4.
- NUM_WR, 1, write ports, 1..2.
- AW, $clog2(NUM_REGS), derived address width; not overridable.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_reg  in  NUM_RD*AW  read addresses; port i is in slice [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data; combinational from rd_reg.
- rd_busy  out  NUM_RD  scoreboard busy bit of each read register; combinational.
- wr_en  in  NUM_WR  per-port write enable.
- wr_reg  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*XLEN  write data.
- issue_en  in  1  marks issue_reg as having a pending producer.
- issue_reg  in  AW  destination register being issued.
- any_busy  out  1  OR of all busy bits; registered view of the state.

## Operation
- Storage is regs[1..NUM_REGS-1], XLEN bits each.
- Reads from register 0 always return 0, and rd_busy for register 0 is always 0.
- Write: on a rising edge with wr_en[j]=1 and wr_reg[j]!=0, regs[wr_reg[j]] <= wr_data[j]. Writes to register 0 are dropped.
- Write collision: if two ports write the same register in one cycle, the highest-index port wins.
- Scoreboard: one busy bit per register, busy[0] is constant 0.
- Set: issue_en=1 and issue_reg!=0 sets busy[issue_reg] at the next edge.
- Clear: a valid write (wr_en=1, address !=0) clears busy[wr_reg] at the next edge.
- Simultaneous issue and write to the same register: set wins, and busy stays 1 because a new producer is pending. The write data is still committed.
- Issue to a register that is already busy is legal; busy stays 1.
- Reset (rst_n=0 at an edge): all regs and busy bits go to 0. This takes priority over any concurrent write or issue.
- Reset output values:
  - rd_data = 0 for every address;
  - rd_busy = 0;
  - any_busy = 0.
- any_busy reflects the busy vector as it stands after the edge.

## Timing
- Read latency is 0 cycles: combinational from rd_reg and the stored state.
- Write latency is 1 edge. Data written at edge N is visible on rd_data after edge N.
- A same-cycle read of a register being written returns the old value, unless bypass is compiled in (see Configuration).
- Busy set/clear latency is 1 edge.
- No handshake: the producer must not drive wr_en to a register it did not issue. This is not checked in RTL.
- Reset mid-stream: a write or issue presented in the reset cycle is lost.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - Write-first forwarding. A read whose address matches an active same-cycle write (address !=0) returns that wr_data, using highest-index-port priority.
  - rd_busy for that address reads 0, unless issue_en targets the same address in that cycle.
  - Forwarding adds a combinational wr_data -> rd_data path.
- REG_FILE_BYPASS_EN undefined:
  - Read-old behaviour: rd_data and rd_busy reflect state before the edge only.
  - There is no combinational path from any write or issue input to any output.

## Test plan
- Reset check: assert rst_n=0 for 1 edge, then read all 32 addresses on both ports. Required: rd_data=0 and rd_busy=0 everywhere, and any_busy=0.
- Write and read back: write x5=0xDEADBEEF, then read x5 on port 0 and x0 on port 1 on the next cycle. Required: 0xDEADBEEF and 0.
- x0 protection: with wr_en=1, wr_reg=0, wr_data=0xFFFFFFFF, and issue_reg=0 with issue_en=1. Required: reading x0 gives 0, rd_busy=0, and any_busy stays 0.
- Port collision (NUM_WR=2): both ports write x7 in one cycle, with 0x1111 on port 0 and 0x2222 on port 1. Required: x7 reads 0x2222.
- Scoreboard sequence:
  - issue x3: busy[x3]=1 on the next cycle;
  - write x3 together with a re-issue of x3 in the same cycle: busy stays 1 and the data is committed;
  - a later write of x3 alone: busy clears and any_busy=0.
- Same-cycle read/write of x9 (old value 0xA, new value 0xB):
  - with REG_FILE_BYPASS_EN: read returns 0xB;
  - without it: read returns 0xA, and 0xB appears after the edge.
- Also run 1000 random cycles scored against the reference model with forwarding matching the build.
